// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between packet sources, the round-robin arbiter and the FIFO RAM.
// The master side drives requests and full; the slave side (arbiter) answers.
interface fifo_wr_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned NUM_REQ    = 4
);
   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned PTR_W = ADDR_WIDTH + 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          full;
   logic                          wr_en;
   logic [DATA_WIDTH-1:0]         wr_data;
   logic [ADDR_WIDTH-1:0]         wr_addr;
   logic [PTR_W-1:0]              wr_ptr;
   logic [PTR_W-1:0]              g_wr_ptr;
   logic [ID_W-1:0]               grant_id;
   logic                          busy;

   modport master (
      output req_valid, req_data, req_last, full,
      input  req_ready, wr_en, wr_data, wr_addr, wr_ptr, g_wr_ptr, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, req_last, full,
      output req_ready, wr_en, wr_data, wr_addr, wr_ptr, g_wr_ptr, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sequencer for the async FIFO write port: shares the port among
// NUM_REQ packet sources and owns the binary and gray write pointers.
module fifo_wr_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_BURST  = 8
) (
   input  logic             clk_A,
   input  logic             rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned PTR_W = ADDR_WIDTH + 1;
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, XFER} state_t;

   state_t                state;
   logic [ID_W-1:0]       grant_id;
   logic [ID_W-1:0]       rr_last;
   logic [CNT_W-1:0]      beat_cnt;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      g_wr_ptr;
   logic                  busy;

   logic [ID_W-1:0]       pick;
   logic                  pick_vld;
   logic [ID_W:0]         cand;
   logic [NUM_REQ-1:0]    ready_c;
   logic [DATA_WIDTH-1:0] data_c;
   logic                  beat_c;
   logic                  exit_c;
   logic [PTR_W-1:0]      wr_ptr_nxt;

   // First valid requester after rr_last, wrapping at NUM_REQ
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         cand = (ID_W+1)'(rr_last) + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
         if (!pick_vld && bus.req_valid[cand[ID_W-1:0]]) begin
            pick     = cand[ID_W-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   // Owner-only handshake; nothing here looks at other requesters' valid
   always_comb begin
      ready_c = '0;
      data_c  = '0;
      if (state == XFER) begin
         ready_c = NUM_REQ'(!bus.full) << grant_id;
         data_c  = DATA_WIDTH'(bus.req_data >> (grant_id * DATA_WIDTH));
      end
   end

   assign beat_c     = (state == XFER) && bus.req_valid[grant_id] && !bus.full;
   assign exit_c     = bus.req_last[grant_id] || (beat_cnt == CNT_W'(MAX_BURST - 1));
   assign wr_ptr_nxt = wr_ptr + PTR_W'(1);

   always_ff @(posedge clk_A or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_last  <= ID_W'(NUM_REQ - 1);
         beat_cnt <= '0;
         wr_ptr   <= '0;
         g_wr_ptr <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant_id <= pick;
                  state    <= XFER;
                  busy     <= 1'b1;
               end
            end
            XFER: begin
               if (beat_c) begin
                  wr_ptr   <= wr_ptr_nxt;
                  g_wr_ptr <= wr_ptr_nxt ^ (wr_ptr_nxt >> 1);
                  // Packet end or burst cap hands the port to the next requester
                  if (exit_c) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     rr_last  <= grant_id;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.wr_en     = beat_c;
   assign bus.wr_data   = data_c;
   assign bus.wr_addr   = wr_ptr[ADDR_WIDTH-1:0];
   assign bus.wr_ptr    = wr_ptr;
   assign bus.g_wr_ptr  = g_wr_ptr;
   assign bus.grant_id  = grant_id;
   assign bus.busy      = busy;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queued packet sources with random valid/full,
// checked each cycle against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;
   localparam int DW   = 8;
   localparam int AW   = 3;
   localparam int NR   = 4;
   localparam int MB   = 8;
   localparam int IW   = 2;
   localparam int PMOD = 16;

   logic clk_A = 1'b0;
   logic rst   = 1'b0;
   always #5 clk_A = ~clk_A;

   fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
      .clk_A (clk_A),
      .rst   (rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [DW:0]   src_q [NR][$];
   int            vprob [NR];
   bit            drv_valid [NR];
   bit            drv_last [NR];
   logic [DW-1:0] drv_data [NR];
   int            full_pct;
   bit            full_drv;
   bit            full_now;

   // Model: owner (-1 when no grant), last served, beats in grant, pointer
   int m_owner, m_gid, m_rr, m_beats, m_ptr, writes;
   int grants [$];

   function automatic logic [AW:0] gray(input int b);
      logic [AW:0] v;
      v = (AW+1)'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic bit same_seq(input int a[$], input int b[$]);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[i]) if (a[i] != b[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit pending();
      bit p;
      p = (m_owner >= 0);
      for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic enqueue(input int r, input int len, input int base);
      for (int j = 0; j < len; j++) src_q[r].push_back({(j == len - 1), DW'(base + j)});
   endtask

   task automatic drive_inputs();
      logic [NR-1:0]    v, l;
      logic [NR*DW-1:0] d;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
         if (src_q[i].size() > 0) begin
            drv_valid[i] = ($urandom_range(99) < vprob[i]);
            drv_data[i]  = src_q[i][0][DW-1:0];
            drv_last[i]  = src_q[i][0][DW];
         end else begin
            drv_valid[i] = 1'b0;
            drv_data[i]  = DW'($urandom);
            drv_last[i]  = 1'($urandom);
         end
         v |= NR'(drv_valid[i]) << i;
         l |= NR'(drv_last[i]) << i;
         d |= (NR*DW)'(drv_data[i]) << (i * DW);
      end
      full_now      = (full_pct > 0) ? ($urandom_range(99) < full_pct) : full_drv;
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
      bus.full      = full_now;
   endtask

   // One clock: drive, compare outputs at negedge, advance model at posedge
   task automatic cycle(input string tag);
      logic [NR-1:0] rdy, exp_rdy;
      logic          exp_en;
      logic [DW-1:0] exp_d;
      int            c;
      drive_inputs();
      @(negedge clk_A);
      exp_rdy = '0; exp_en = 1'b0; exp_d = '0;
      if (m_owner >= 0) begin
         exp_d = drv_data[m_owner];
         if (!full_now) begin
            exp_rdy = NR'(1) << m_owner;
            exp_en  = drv_valid[m_owner];
         end
      end
      checks++;
      if ({bus.req_ready, bus.wr_en, bus.wr_data} !== {exp_rdy, exp_en, exp_d}) begin
         failures++;
         $display("FAIL %s handshake t=%0t ready/en/data got=%b/%b/%h exp=%b/%b/%h", tag, $time,
                  bus.req_ready, bus.wr_en, bus.wr_data, exp_rdy, exp_en, exp_d);
      end
      checks++;
      if ({bus.wr_ptr, bus.wr_addr, bus.g_wr_ptr, bus.grant_id, bus.busy} !==
          {(AW+1)'(m_ptr), AW'(m_ptr), gray(m_ptr), IW'(m_gid), 1'(m_owner >= 0)}) begin
         failures++;
         $display("FAIL %s state t=%0t ptr/addr/gray/gid/busy got=%0d/%0d/%b/%0d/%b exp=%0d/%0d/%b/%0d/%b",
                  tag, $time, bus.wr_ptr, bus.wr_addr, bus.g_wr_ptr, bus.grant_id, bus.busy,
                  m_ptr, m_ptr % 8, gray(m_ptr), m_gid, m_owner >= 0);
      end
      rdy = bus.req_ready;
      @(posedge clk_A);
      if (m_owner < 0) begin
         for (int k = 1; k <= NR; k++) begin
            c = (m_rr + k) % NR;
            if (m_owner < 0 && drv_valid[c]) m_owner = c;
         end
         if (m_owner >= 0) begin
            m_gid = m_owner; m_beats = 0; grants.push_back(m_owner);
         end
      end else if (!full_now && drv_valid[m_owner]) begin
         writes++;
         m_ptr = (m_ptr + 1) % PMOD;
         m_beats++;
         if (drv_last[m_owner] || m_beats == MB) begin
            m_rr = m_owner; m_owner = -1; m_beats = 0;
         end
      end
      for (int i = 0; i < NR; i++)
         if (((rdy >> i) & NR'(1)) != '0 && drv_valid[i]) void'(src_q[i].pop_front());
      #1;
   endtask

   task automatic run_until_done(input string tag, input int budget, output int n);
      n = 0;
      while (pending() && n < budget) begin
         cycle(tag);
         n++;
      end
      checks++;
      if (pending()) begin
         failures++;
         $display("FAIL %s timeout got=%0d cycles required=drained", tag, n);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int i = 0; i < NR; i++) begin
         src_q[i].delete(); vprob[i] = 100; drv_valid[i] = 1'b0;
      end
      bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.full = 1'b0;
      full_drv = 1'b0; full_pct = 0; full_now = 1'b0;
      m_owner = -1; m_gid = 0; m_rr = NR - 1; m_beats = 0; m_ptr = 0; writes = 0;
      grants.delete();
      repeat (2) @(negedge clk_A);
      rst = 1'b1;
      @(posedge clk_A);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.req_valid = NR'($urandom); bus.req_data = (NR*DW)'($urandom);
      bus.req_last  = NR'($urandom); bus.full = 1'($urandom);
      #1;
      checks++;
      if ({bus.wr_en, bus.req_ready, bus.busy, bus.wr_data} !== '0) begin
         failures++;
         $display("FAIL reset_hs got en=%b ready=%b busy=%b data=%h required all 0",
                  bus.wr_en, bus.req_ready, bus.busy, bus.wr_data);
      end
      @(posedge clk_A); #1;
      checks++;
      if ({bus.wr_ptr, bus.g_wr_ptr, bus.grant_id, bus.wr_addr} !== '0) begin
         failures++;
         $display("FAIL reset_ptr got ptr=%0d gray=%b gid=%0d required 0", bus.wr_ptr, bus.g_wr_ptr, bus.grant_id);
      end
      do_reset();
      cycle("reset_idle");
   endtask

   task automatic test_single();
      int n;
      int exp_g [$];
      do_reset();
      enqueue(0, 3, 'hA0);
      run_until_done("single", 20, n);
      exp_g = '{0};
      checks++;
      if (!same_seq(grants, exp_g)) begin
         failures++; $display("FAIL single_grants got=%p required=%p", grants, exp_g);
      end
      checks++;
      if (bus.wr_ptr !== 4'd3 || bus.g_wr_ptr !== 4'b0010 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL single_end got ptr=%0d gray=%b busy=%b required 3/0010/0", bus.wr_ptr, bus.g_wr_ptr, bus.busy);
      end
      checks++;
      if (n != 4) begin failures++; $display("FAIL single_latency got=%0d cycles required=4", n); end
   endtask

   task automatic test_round_robin();
      int n;
      int exp_g [$];
      do_reset();
      enqueue(0, 1, 'h10); enqueue(0, 1, 'h11);
      enqueue(1, 1, 'h20); enqueue(2, 1, 'h30); enqueue(3, 1, 'h40);
      run_until_done("rr", 40, n);
      exp_g = '{0, 1, 2, 3, 0};
      checks++;
      if (!same_seq(grants, exp_g)) begin
         failures++; $display("FAIL rr_order got=%p required=%p", grants, exp_g);
      end
      checks++;
      if (n != 10) begin failures++; $display("FAIL rr_cycles got=%0d required=10", n); end
   endtask

   task automatic test_full_stall();
      int n;
      do_reset();
      enqueue(1, 3, 'h50);
      n = 0;
      while (writes < 1 && n < 10) begin cycle("stall_pre"); n++; end
      full_drv = 1'b1;
      repeat (5) cycle("stall_full");
      checks++;
      if (bus.wr_ptr !== 4'd1 || bus.grant_id !== 2'd1 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL stall_hold got ptr=%0d gid=%0d busy=%b required 1/1/1", bus.wr_ptr, bus.grant_id, bus.busy);
      end
      full_drv = 1'b0;
      run_until_done("stall_post", 20, n);
      checks++;
      if (writes != 3 || bus.wr_ptr !== 4'd3) begin
         failures++; $display("FAIL stall_done got writes=%0d ptr=%0d required 3/3", writes, bus.wr_ptr);
      end
   endtask

   task automatic test_burst_cap();
      int n;
      int exp_g [$];
      do_reset();
      enqueue(2, 20, 'h60);
      enqueue(3, 3, 'hB0);
      run_until_done("burst", 100, n);
      exp_g = '{2, 3, 2, 2};
      checks++;
      if (!same_seq(grants, exp_g)) begin
         failures++; $display("FAIL burst_order got=%p required=%p", grants, exp_g);
      end
      checks++;
      if (writes != 23 || bus.wr_ptr !== 4'd7) begin
         failures++; $display("FAIL burst_count got writes=%0d ptr=%0d required 23/7", writes, bus.wr_ptr);
      end
   endtask

   task automatic test_wrap();
      int          n, left, len, prev_p;
      logic [AW:0] prev_g;
      bit          wrapped;
      do_reset();
      full_pct = 25;
      left = 19;
      while (left > 0) begin
         len = $urandom_range(5, 1);
         if (len > left) len = left;
         enqueue(0, len, 19 - left);
         left -= len;
      end
      prev_g = bus.g_wr_ptr; prev_p = int'(bus.wr_ptr); wrapped = 1'b0; n = 0;
      while (pending() && n < 300) begin
         cycle("wrap");
         n++;
         if (bus.g_wr_ptr !== prev_g) begin
            checks++;
            if ($countones(bus.g_wr_ptr ^ prev_g) != 1) begin
               failures++; $display("FAIL wrap_gray_hd got %b->%b required one bit change", prev_g, bus.g_wr_ptr);
            end
         end
         if (prev_p == 15 && bus.wr_ptr == 4'd0) wrapped = 1'b1;
         prev_g = bus.g_wr_ptr; prev_p = int'(bus.wr_ptr);
      end
      checks++;
      if (!wrapped || writes != 19 || bus.wr_ptr !== 4'd3 || pending()) begin
         failures++;
         $display("FAIL wrap_end got wrapped=%b writes=%0d ptr=%0d required 1/19/3", wrapped, writes, bus.wr_ptr);
      end
   endtask

   task automatic test_midburst_reset();
      int n;
      int exp_g [$];
      do_reset();
      enqueue(1, 10, 'hC0);
      n = 0;
      while (writes < 3 && n < 20) begin cycle("mid_pre"); n++; end
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.wr_en, bus.req_ready, bus.busy, bus.wr_ptr, bus.g_wr_ptr, bus.grant_id} !== '0) begin
         failures++;
         $display("FAIL mid_reset got en=%b ready=%b busy=%b ptr=%0d gray=%b gid=%0d required all 0",
                  bus.wr_en, bus.req_ready, bus.busy, bus.wr_ptr, bus.g_wr_ptr, bus.grant_id);
      end
      do_reset();
      enqueue(2, 2, 'hD0);
      run_until_done("mid_post", 20, n);
      exp_g = '{2};
      checks++;
      if (!same_seq(grants, exp_g) || bus.wr_ptr !== 4'd2) begin
         failures++; $display("FAIL mid_restart got grants=%p ptr=%0d required '{2}/2", grants, bus.wr_ptr);
      end
   endtask

   task automatic test_random();
      int n, total;
      do_reset();
      full_pct = 20;
      total = 0;
      for (int round = 0; round < 3; round++) begin
         for (int i = 0; i < NR; i++) begin
            vprob[i] = $urandom_range(100, 30);
            for (int p = $urandom_range(4, 1); p > 0; p--) begin
               n = $urandom_range(12, 1);
               enqueue(i, n, $urandom_range(255));
               total += n;
            end
         end
         run_until_done("random", 5000, n);
      end
      checks++;
      if (writes != total || bus.wr_ptr !== 4'(total % PMOD)) begin
         failures++;
         $display("FAIL random_count got writes=%0d ptr=%0d required %0d/%0d", writes, bus.wr_ptr, total, total % PMOD);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full_stall();
      test_burst_cap();
      test_wrap();
      test_midburst_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
